// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse_shaper datapath.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pulse_state_t;

  // Width of the gap down-counter; never narrower than one bit.
  function automatic int gap_cnt_width(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_shaper_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; chain clears to 0 on reset.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_shaper.sv
// Turns rising edges of an asynchronous request into queued, gap-separated
// single-cycle pulses on signal_a.
module pulse_shaper
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GAP         = 1,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_in,
  input  logic              pulse_en,
  input  logic              ovf_clr,
  output logic              signal_a,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              busy,
  output logic              overflow
);

  localparam int                GCW      = gap_cnt_width(GAP);
  localparam logic [GCW-1:0]    GAP_LOAD = GCW'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic req_sync;
  logic req_last_q, req_last_d;
  logic rise;
  logic issue;
  logic ovf_set;

  pulse_state_t      state_q, state_d;
  logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;
  logic              overflow_q, overflow_d;
  logic              signal_a_q, signal_a_d;
  logic              busy_q, busy_d;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (req_in),
    .q    (req_sync)
  );

  always_comb begin
    req_last_d = req_sync;
    rise       = req_sync & ~req_last_q;
  end

  // The parameter GAP shadows the enum literal, so states are package-qualified.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    issue     = 1'b0;
    case (state_q)
      pulse_pkg::IDLE: begin
        if ((pend_cnt_q != '0) && pulse_en) begin
          state_d = pulse_pkg::PULSE;
          issue   = 1'b1;
        end
      end
      pulse_pkg::PULSE: begin
        state_d   = pulse_pkg::GAP;
        gap_cnt_d = GAP_LOAD;
      end
      pulse_pkg::GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = pulse_pkg::IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = pulse_pkg::IDLE;
      end
    endcase
  end

  // A simultaneous event and issue cancel out; a lost event latches overflow.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    ovf_set    = 1'b0;
    if (rise && !issue) begin
      if (pend_cnt_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_cnt_d = pend_cnt_q + 1'b1;
      end
    end else if (issue && !rise) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end

    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    signal_a_d = (state_d == pulse_pkg::PULSE);
    busy_d     = (state_d != pulse_pkg::IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_last_q <= 1'b0;
      state_q    <= pulse_pkg::IDLE;
      gap_cnt_q  <= '0;
      pend_cnt_q <= '0;
      overflow_q <= 1'b0;
      signal_a_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      req_last_q <= req_last_d;
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      pend_cnt_q <= pend_cnt_d;
      overflow_q <= overflow_d;
      signal_a_q <= signal_a_d;
      busy_q     <= busy_d;
    end
  end

  assign signal_a = signal_a_q;
  assign pend_cnt = pend_cnt_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_shaper.sv
// Scoreboard bench for pulse_shaper: directed scenarios plus random traffic
// checked against an event/timing reference model.
module tb_pulse_shaper;

  localparam int SYNC = 2;
  localparam int GAPC = 3;
  localparam int PW   = 2;
  localparam int MAXP = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_in = 1'b0;
  logic          pulse_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          signal_a;
  logic [PW-1:0] pend_cnt;
  logic          busy;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  pulse_shaper #(
    .SYNC_STAGES(SYNC),
    .GAP        (GAPC),
    .PEND_W     (PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_in  (req_in),
    .pulse_en(pulse_en),
    .ovf_clr (ovf_clr),
    .signal_a(signal_a),
    .pend_cnt(pend_cnt),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An edge counts when the request, seen SYNC edges ago, was high and the
  // sample before it low. A pulse may issue only GAP+2 edges after the last.
  int  n = 0;
  int  m_pend = 0;
  bit  m_ovf = 1'b0;
  int  last_p = -1000;
  bit  hist[SYNC+1];
  int  exp_q[$];
  bit  m_rise, m_issue, m_lost;

  initial begin : model
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pend = 0;
        m_ovf  = 1'b0;
        last_p = -1000;
        exp_q.delete();
        for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
      end else begin
        n++;
        m_issue = (m_pend > 0) && pulse_en && (n - last_p >= GAPC + 2);
        m_rise  = hist[SYNC-1] && !hist[SYNC];
        m_lost  = 1'b0;
        if (m_rise && !m_issue) begin
          if (m_pend == MAXP) m_lost = 1'b1;
          else m_pend++;
        end else if (m_issue && !m_rise) begin
          m_pend--;
        end
        if (m_lost) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (m_issue) begin
          last_p = n;
          exp_q.push_back(n);
        end
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = req_in;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_signal_a", signal_a, 0);
        chk("rst_pend_cnt", pend_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
      end else begin
        chk("pend_cnt", pend_cnt, m_pend);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, (n - last_p <= GAPC) ? 1 : 0);
        if (signal_a) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse_cycle", n, -1);
          end else begin
            chk("pulse_cycle", n, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end else if (exp_q.size() != 0 && exp_q[0] <= n) begin
          chk("missed_pulse_cycle", -1, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  a_one_cycle: assert property (@(posedge clk) disable iff (!reset) signal_a |-> !$past(signal_a))
    else begin
      bad++;
      $display("FAIL pulse_width: signal_a high on consecutive edges at t=%0t", $time);
    end

  a_no_wrap: assert property (@(posedge clk) disable iff (!reset)
                              ($past(pend_cnt) == MAXP) |-> (pend_cnt != 0))
    else begin
      bad++;
      $display("FAIL pend_wrap: pend_cnt wrapped from max to 0 at t=%0t", $time);
    end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic req_event(input int hi, input int lo);
    req_in = 1'b1;
    ticks(hi);
    req_in = 1'b0;
    ticks(lo);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || pend_cnt != 0) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_idle_in_time"}, (k < 200) ? 1 : 0, 1);
  endtask

  int times[$];
  int pends[$];
  int hold;
  int k;

  initial begin : stim
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    pulse_en = 1'b1;
    ticks(2);

    // Single isolated event.
    req_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("single_pend_at_k2", pend_cnt, 1);
    chk("single_sig_at_k2", signal_a, 0);
    @(posedge clk);
    #1;
    chk("single_sig_at_k3", signal_a, 1);
    chk("single_pend_at_k3", pend_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("single_busy_end_gap", busy, 1);
    chk("single_sig_low_gap", signal_a, 0);
    @(posedge clk);
    #1;
    chk("single_busy_after", busy, 0);
    tick();
    req_in = 1'b0;
    wait_idle("single");

    // Burst of three held back by pulse_en, then released.
    pulse_en = 1'b0;
    ticks(2);
    repeat (3) req_event(2, 2);
    ticks(SYNC + 2);
    chk("burst_pend3", pend_cnt, 3);
    chk("burst_sig_held", signal_a, 0);
    pulse_en = 1'b1;
    times.delete();
    pends.delete();
    for (int i = 0; i < 3 * (GAPC + 2) + 6; i++) begin
      @(posedge clk);
      #1;
      if (signal_a) begin
        times.push_back(i);
        pends.push_back(int'(pend_cnt));
      end
    end
    chk("burst_npulses", times.size(), 3);
    if (times.size() == 3) begin
      chk("burst_space1", times[1] - times[0], GAPC + 2);
      chk("burst_space2", times[2] - times[1], GAPC + 2);
      chk("burst_pend_step1", pends[0], 2);
      chk("burst_pend_step2", pends[1], 1);
      chk("burst_pend_step3", pends[2], 0);
    end
    tick();
    wait_idle("burst");

    // Saturation and overflow clear.
    pulse_en = 1'b0;
    repeat (3) req_event(2, 2);
    ticks(1);
    chk("sat_pend_after3", pend_cnt, 3);
    chk("sat_ovf_after3", overflow, 0);
    req_event(2, 2);
    ticks(1);
    chk("sat_ovf_after4", overflow, 1);
    req_event(2, 2);
    ticks(1);
    chk("sat_pend_after5", pend_cnt, 3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sat_ovf_cleared", overflow, 0);
    chk("sat_pend_kept", pend_cnt, 3);
    pulse_en = 1'b1;
    wait_idle("sat");

    // Event arriving on the same edge as an issue.
    pulse_en = 1'b0;
    req_event(2, 2);
    ticks(2);
    chk("simul_pend_pre", pend_cnt, 1);
    req_in = 1'b1;
    tick();
    tick();
    pulse_en = 1'b1;
    @(posedge clk);
    #1;
    chk("simul_sig", signal_a, 1);
    chk("simul_pend_kept", pend_cnt, 1);
    repeat (GAPC + 2) @(posedge clk);
    #1;
    chk("simul_second_sig", signal_a, 1);
    chk("simul_pend_zero", pend_cnt, 0);
    tick();
    req_in = 1'b0;
    wait_idle("simul");

    // Reset while a pulse is on the output with two more pending.
    pulse_en = 1'b0;
    req_event(2, 2);
    req_event(2, 2);
    req_in = 1'b1;
    ticks(SYNC + 2);
    chk("rstmid_pend3", pend_cnt, 3);
    pulse_en = 1'b1;
    k = 0;
    while (!(signal_a && pend_cnt == 2) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rstmid_reached", (k < 50) ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    chk("rstmid_sig", signal_a, 0);
    chk("rstmid_pend", pend_cnt, 0);
    chk("rstmid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (signal_a) k++;
    end
    chk("rstmid_one_pulse", k, 1);
    tick();
    req_in = 1'b0;
    wait_idle("rstmid");

    // Random traffic.
    hold = 1;
    for (int i = 0; i < 2500; i++) begin
      hold--;
      if (hold <= 0) begin
        req_in = ~req_in;
        hold = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 19) == 0) pulse_en = ~pulse_en;
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end
    ovf_clr = 1'b0;
    req_in = 1'b0;
    pulse_en = 1'b1;
    ticks(SYNC + 2);
    wait_idle("random");
    ticks(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
